// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame geometry and bit-timer width.
// Used by both the UART receiver and the UART transmitter.
package uart_pkg;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START_BIT  = 3'd1;
  localparam logic [2:0] DATA_BITS  = 3'd2;
  localparam logic [2:0] STOP_BIT   = 3'd3;
  localparam logic [2:0] CLEANUP    = 3'd4;
  localparam logic [2:0] PARITY_BIT = 3'd5;

  localparam int UART_DATA_BITS = 8;
  localparam int BIT_TIMER_W    = 8;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter shared by the UART transmitter and receiver.
// Pulses bit_end while enabled on the last cycle of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam logic [BIT_TIMER_W-1:0] LAST_COUNT = BIT_TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_TIMER_W-1:0] ZERO_COUNT = {BIT_TIMER_W{1'b0}};
  localparam logic [BIT_TIMER_W-1:0] ONE_COUNT  = {{(BIT_TIMER_W-1){1'b0}}, 1'b1};

  logic [BIT_TIMER_W-1:0] count_r;

  // Count 0..CLKS_PER_BIT-1 while enabled, wrapping at the end of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= ZERO_COUNT;
    end else if (clear) begin
      count_r <= ZERO_COUNT;
    end else if (enable) begin
      if (count_r == LAST_COUNT) begin
        count_r <= ZERO_COUNT;
      end else begin
        count_r <= count_r + ONE_COUNT;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign bit_end = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1, LSB first, idle-high line, CLKS_PER_BIT cycles per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] input_Byte,
  output logic       output_serial,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] AFTER_DATA = PARITY_BIT;
  logic parity_r;
`else
  localparam logic [2:0] AFTER_DATA = STOP_BIT;
`endif

  logic [2:0] state_r;
  logic [2:0] bit_index_r;
  logic [7:0] shift_r;
  logic       timer_clear_s;
  logic       timer_en_s;
  logic       bit_end_s;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .bit_end(bit_end_s)
  );

  // Bit timer runs only while a line bit is being held.
  always_comb begin
    timer_clear_s = 1'b0;
    timer_en_s    = 1'b0;
    case (state_r)
      START_BIT, DATA_BITS, STOP_BIT: timer_en_s = 1'b1;
`ifdef UART_TX_PARITY_EN
      PARITY_BIT:                     timer_en_s = 1'b1;
`endif
      default:                        timer_clear_s = 1'b1;
    endcase
  end

  // Frame sequencing; line level registered one cycle behind the state it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      bit_index_r   <= 3'd0;
      shift_r       <= 8'h00;
      output_serial <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          output_serial <= 1'b1;
          busy          <= 1'b0;
          done          <= 1'b0;
          bit_index_r   <= 3'd0;
          if (start) begin
            shift_r <= input_Byte;
            state_r <= START_BIT;
`ifdef UART_TX_PARITY_EN
            parity_r <= even_parity(input_Byte);
`endif
          end
        end
        START_BIT: begin
          output_serial <= 1'b0;
          busy          <= 1'b1;
          done          <= 1'b0;
          if (bit_end_s) state_r <= DATA_BITS;
        end
        DATA_BITS: begin
          output_serial <= shift_r[0];
          busy          <= 1'b1;
          done          <= 1'b0;
          if (bit_end_s) begin
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_index_r == LAST_BIT) begin
              bit_index_r <= 3'd0;
              state_r     <= AFTER_DATA;
            end else begin
              bit_index_r <= bit_index_r + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY_BIT: begin
          output_serial <= parity_r;
          busy          <= 1'b1;
          done          <= 1'b0;
          if (bit_end_s) state_r <= STOP_BIT;
        end
`endif
        STOP_BIT: begin
          output_serial <= 1'b1;
          if (bit_end_s) begin
            state_r <= CLEANUP;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        CLEANUP: begin
          output_serial <= 1'b1;
          busy          <= 1'b0;
          done          <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          // Unreachable encodings recover to an idle, high line.
          state_r       <= IDLE;
          bit_index_r   <= 3'd0;
          output_serial <= 1'b1;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: a timing model predicts accepted bytes,
// a negedge monitor checks every line/busy/done sample of each frame.
module tb_uart_transmitter;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int FC = F * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] input_Byte = 8'h00;
  logic       output_serial;
  logic       busy;
  logic       done;

  uart_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .input_Byte   (input_Byte),
    .output_serial(output_serial),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         edge_n = 0;
  int         ready_at = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Whole frame as the line shows it, bit 0 first: start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = {1'b1, 1'b1, b, 1'b0};
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Drive one edge; the model decides from frame timing alone whether start is accepted.
  task automatic tick(input bit s, input logic [7:0] b, input bit r);
    start = s;
    input_Byte = b;
    rst = r;
    @(posedge clk);
    edge_n++;
    if (r) begin
      ready_at = edge_n + 1;
      exp_q.delete();
    end else if (s && edge_n >= ready_at) begin
      exp_q.push_back(b);
      ready_at = edge_n + FC + 2;
    end
    #1;
  endtask

  int          k = -1;
  logic [10:0] fv = 11'h7FF;
  bit          rst_prev = 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_prev) begin
        chk("reset_line", output_serial, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        k = -1;
      end else begin
        if (k < 0) begin
          if (output_serial === 1'b0) begin
            k = 0;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_frame: got a start bit, want none (edge %0d)", edge_n);
              fv = frame_of(8'h00);
            end else begin
              fv = frame_of(exp_q.pop_front());
            end
          end else begin
            chk("idle_busy", busy, 1'b0);
            chk("idle_done", done, 1'b0);
          end
        end
        if (k >= 0) begin
          chk("frame_line", output_serial, fv[k / C]);
          chk("frame_busy", busy, k < FC - 1);
          chk("frame_done", done, k == FC - 1);
          k = (k == FC - 1) ? -1 : k + 1;
        end
      end
    end
    rst_prev = rst;
  end

  initial begin
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    mon_en = 1'b1;
    tick(1'b0, 8'h00, 1'b0);

    // Single frame, mixed bit pattern.
    tick(1'b1, 8'hA5, 1'b0);
    repeat (FC + 3) tick(1'b0, 8'hA5, 1'b0);

    // Start with a new byte mid-frame must be ignored.
    tick(1'b1, 8'h81, 1'b0);
    repeat (14) tick(1'b0, 8'h81, 1'b0);
    tick(1'b1, 8'h3C, 1'b0);
    repeat (FC) tick(1'b0, 8'h3C, 1'b0);

    // Reset at frame cycle 20, then a clean frame.
    tick(1'b1, 8'hC3, 1'b0);
    repeat (19) tick(1'b0, 8'hC3, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h55, 1'b0);
    repeat (FC + 3) tick(1'b0, 8'h55, 1'b0);

    // Start held high: frames at minimum spacing, 0x00 then 0xFF.
    for (int i = 0; i < 2 * (FC + 2); i++)
      tick(1'b1, (i < FC + 2) ? 8'h00 : 8'hFF, 1'b0);
    repeat (FC + 3) tick(1'b0, 8'h00, 1'b0);

    // Random starts, bytes and occasional resets.
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 299) == 0);
    repeat (FC + 4) tick(1'b0, 8'h00, 1'b0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d frames never sent, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
